// File: rtl/div_seq_if.sv
// ---------------------------------------------------------------------------
// div_seq_if
//   Request/result bundle between the execute stage (master) and the
//   iterative divider (slave).
//
//   Handshake semantics (both channels): a transfer happens in a cycle where
//   valid and ready are both 1 at the rising clock edge. The request channel
//   is div_req_valid/div_req_ready with div_signed/div_src1/div_src2 as
//   payload. The result channel is div_res_valid/div_res_ready with
//   div_quot/div_rem as payload. The result payload is held stable while
//   div_res_valid is 1 and not yet taken. div_cancel is a sideband flush that
//   overrides both channels. div_busy reports an accepted, unconsumed
//   operation.
//
//   Signals
//     div_req_valid  master->slave  request present
//     div_req_ready  slave->master  request can be accepted this cycle
//     div_signed     master->slave  1 = DIV, 0 = DIVU
//     div_src1       master->slave  dividend
//     div_src2       master->slave  divisor
//     div_cancel     master->slave  pipeline flush
//     div_res_valid  slave->master  quotient/remainder valid
//     div_res_ready  master->slave  consumer takes the result
//     div_quot       slave->master  quotient
//     div_rem        slave->master  remainder
//     div_busy       slave->master  operation in flight or result pending
// ---------------------------------------------------------------------------
interface div_seq_if #(
    parameter int DW = 32
);
    logic          div_req_valid;
    logic          div_req_ready;
    logic          div_signed;
    logic [DW-1:0] div_src1;
    logic [DW-1:0] div_src2;
    logic          div_cancel;
    logic          div_res_valid;
    logic          div_res_ready;
    logic [DW-1:0] div_quot;
    logic [DW-1:0] div_rem;
    logic          div_busy;

    modport master (
        output div_req_valid, div_signed, div_src1, div_src2, div_cancel, div_res_ready,
        input  div_req_ready, div_res_valid, div_quot, div_rem, div_busy
    );

    modport slave (
        input  div_req_valid, div_signed, div_src1, div_src2, div_cancel, div_res_ready,
        output div_req_ready, div_res_valid, div_quot, div_rem, div_busy
    );
endinterface

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//   Iterative radix-2 restoring divider for DIV/DIVU. One quotient bit per
//   cycle, MSB first, DW compute cycles per operation. Signed operands are
//   converted to magnitudes at accept and the signs are reapplied when the
//   result is registered, so outputs are stable for as long as they are valid.
//
//   Ports
//     clk          in   core clock
//     reset        in   synchronous, active-high reset
//     bus          slave side of div_seq_if (request, result, cancel, busy)
//     dbg_state_o  out  current sequencer state (IDLE=0, CALC=1, DONE=2)
//
//   Sequencer: IDLE -> CALC (DW cycles) -> DONE -> IDLE.
//   Request-to-result latency is DW+1 cycles. Cancel returns to IDLE from
//   CALC or DONE and blocks acceptance while in IDLE.
// ---------------------------------------------------------------------------
module div_seq #(
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_seq_if.slave   bus,
    output logic [1:0] dbg_state_o
);
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          dz_q, dz_d;
    logic [DW-1:0] dvd_q, dvd_d;     // dividend magnitude; quotient bits shift in at the LSB
    logic [DW-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [DW-1:0] prem_q, prem_d;   // partial remainder
    logic [DW-1:0] src1_q, src1_d;   // original dividend, returned on divide-by-zero
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;

    logic          accept;
    logic          sgn1, sgn2;
    logic [DW:0]   rem_sh;
    logic [DW+1:0] trial;
    logic          qbit;
    logic [DW-1:0] rem_step;
    logic [DW-1:0] quot_step;
    logic          last;

    assign bus.div_req_ready = (state_q == IDLE) && !bus.div_cancel;
    assign accept            = bus.div_req_valid && bus.div_req_ready;

    assign sgn1 = bus.div_signed & bus.div_src1[DW-1];
    assign sgn2 = bus.div_signed & bus.div_src2[DW-1];

    // The shifted remainder keeps the bit that leaves the top of prem_q: with a
    // divisor above 2^(DW-1) the partial remainder can have its MSB set, and
    // dropping it would under-estimate the trial. One further bit holds the
    // borrow, so trial[DW+1] is the sign of the subtraction.
    assign rem_sh    = {prem_q, dvd_q[DW-1]};
    assign trial     = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign qbit      = ~trial[DW+1];
    // On a failed trial rem_sh is below the divisor, so its top bit is zero.
    assign rem_step  = qbit ? trial[DW-1:0] : rem_sh[DW-1:0];
    assign quot_step = {dvd_q[DW-2:0], qbit};
    assign last      = (cnt_q == CW'(DW - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dz_d    = dz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        src1_d  = src1_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    s1_d    = sgn1;
                    s2_d    = sgn2;
                    dvd_d   = sgn1 ? -bus.div_src1 : bus.div_src1;
                    dvs_d   = sgn2 ? -bus.div_src2 : bus.div_src2;
                    dz_d    = (bus.div_src2 == '0);
                    src1_d  = bus.div_src1;
                    prem_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.div_cancel) begin
                    state_d = IDLE;
                end else begin
                    dvd_d  = quot_step;
                    prem_d = rem_step;
                    cnt_d  = cnt_q + 1'b1;
                    if (last) begin
                        state_d = DONE;
                        // Sign fix-up happens here so DONE presents registered values.
                        if (dz_q) begin
                            quot_d = '1;
                            rem_d  = src1_q;
                        end else begin
                            quot_d = (s1_q ^ s2_q) ? -quot_step : quot_step;
                            rem_d  = s1_q ? -rem_step : rem_step;
                        end
                    end
                end
            end
            DONE: begin
                // Cancel and a consumer handshake both end the result; either way
                // it is not presented again.
                if (bus.div_cancel || bus.div_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            src1_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dz_q    <= dz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            src1_q  <= src1_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Status outputs decode registered state only.
    assign bus.div_res_valid = (state_q == DONE);
    assign bus.div_busy      = (state_q != IDLE);
    assign bus.div_quot      = quot_q;
    assign bus.div_rem       = rem_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    div_seq_if #(.DW(DW)) bus();

    div_seq #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_r[$];

    // Every step lands 1 time unit after the rising edge: inputs are driven and
    // outputs sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; signed uses 64-bit arithmetic, which
    // truncates toward zero and wraps the overflow case naturally.
    function automatic void ref_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = DW'(sa / sb);
            r  = DW'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        logic [DW-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = '1;
            3:       v = DW'($urandom_range(0, 20));
            4:       v = -DW'($urandom_range(1, 20));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Presents a request and waits (bounded) for acceptance. Returns in the
    // cycle after the accept cycle, with the request dropped and the operand
    // lines scrambled so the latched values are what matter.
    task automatic issue(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        bus.div_signed    = sgn;
        bus.div_src1      = a;
        bus.div_src2      = b;
        bus.div_req_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.div_req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.div_req_ready !== 1'b1) begin
            $display("FAIL issue_ready: req_ready=%0b required=1", bus.div_req_ready);
            failures++;
        end
        tick();
        bus.div_req_valid = 1'b0;
        bus.div_src1      = $urandom();
        bus.div_src2      = $urandom();
        bus.div_signed    = 1'($urandom_range(0, 1));
    endtask

    // n counts cycles from the accept cycle to the first res_valid cycle.
    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.div_res_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] eq, input logic [DW-1:0] er, input string name);
        int n;
        bus.div_res_ready = 1'b1;
        issue(sgn, a, b);
        wait_valid(n);
        checks++;
        if (n !== DW + 1) begin
            $display("FAIL %s_latency: got=%0d required=%0d", name, n, DW + 1);
            failures++;
        end
        checks++;
        if (bus.div_quot !== eq) begin
            $display("FAIL %s_quot: got=%h required=%h", name, bus.div_quot, eq);
            failures++;
        end
        checks++;
        if (bus.div_rem !== er) begin
            $display("FAIL %s_rem: got=%h required=%h", name, bus.div_rem, er);
            failures++;
        end
        tick();
        checks++;
        if (bus.div_res_valid !== 1'b0 || bus.div_req_ready !== 1'b1) begin
            $display("FAIL %s_after: res_valid=%0b req_ready=%0b required 0/1", name,
                     bus.div_res_valid, bus.div_req_ready);
            failures++;
        end
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.div_req_valid = 1'b0;
        bus.div_signed    = 1'b0;
        bus.div_src1      = '0;
        bus.div_src2      = '0;
        bus.div_cancel    = 1'b0;
        bus.div_res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.div_res_valid !== 1'b0 || bus.div_busy !== 1'b0 || dbg_state !== 2'd0) begin
            $display("FAIL reset_status: res_valid=%0b busy=%0b state=%0d required 0/0/0",
                     bus.div_res_valid, bus.div_busy, dbg_state);
            failures++;
        end
        checks++;
        if (bus.div_quot !== '0 || bus.div_rem !== '0) begin
            $display("FAIL reset_data: quot=%h rem=%h required 0/0", bus.div_quot, bus.div_rem);
            failures++;
        end
        checks++;
        if (bus.div_req_ready !== 1'b1) begin
            $display("FAIL reset_ready: req_ready=%0b required=1", bus.div_req_ready);
            failures++;
        end
        bus.div_cancel = 1'b1;
        #1;
        checks++;
        if (bus.div_req_ready !== 1'b0) begin
            $display("FAIL reset_ready_cancel: req_ready=%0b required=0", bus.div_req_ready);
            failures++;
        end
        bus.div_cancel = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_overflow");
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "divu_by_zero");
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div_by_zero");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, "divu_big_divisor");
    endtask

    task automatic test_hold();
        int n;
        bus.div_res_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd7);
        wait_valid(n);
        checks++;
        if (n !== DW + 1) begin
            $display("FAIL hold_latency: got=%0d required=%0d", n, DW + 1);
            failures++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.div_res_valid !== 1'b1 || bus.div_quot !== 32'd14 || bus.div_rem !== 32'd2 ||
                bus.div_req_ready !== 1'b0 || bus.div_busy !== 1'b1) begin
                $display("FAIL hold_stable: cyc=%0d valid=%0b quot=%h rem=%h ready=%0b busy=%0b required 1/e/2/0/1",
                         i, bus.div_res_valid, bus.div_quot, bus.div_rem, bus.div_req_ready, bus.div_busy);
                failures++;
            end
        end
        bus.div_res_ready = 1'b1;
        #1;
        checks++;
        if (bus.div_req_ready !== 1'b0) begin
            $display("FAIL hold_no_turnaround: req_ready=%0b required=0", bus.div_req_ready);
            failures++;
        end
        tick();
        checks++;
        if (bus.div_res_valid !== 1'b0 || bus.div_busy !== 1'b0 || bus.div_req_ready !== 1'b1) begin
            $display("FAIL hold_release: valid=%0b busy=%0b ready=%0b required 0/0/1",
                     bus.div_res_valid, bus.div_busy, bus.div_req_ready);
            failures++;
        end
    endtask

    task automatic test_cancel();
        int n;
        bit seen;
        bus.div_res_ready = 1'b1;
        issue(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 15; i++) tick();
        bus.div_cancel = 1'b1;
        tick();
        bus.div_cancel = 1'b0;
        #1;
        checks++;
        if (bus.div_busy !== 1'b0 || bus.div_req_ready !== 1'b1 || bus.div_res_valid !== 1'b0) begin
            $display("FAIL cancel_calc: busy=%0b ready=%0b valid=%0b required 0/1/0",
                     bus.div_busy, bus.div_req_ready, bus.div_res_valid);
            failures++;
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.div_res_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL cancel_no_result: res_valid_seen=%0b required=0", seen);
            failures++;
        end
        // Cancel together with a request in IDLE.
        bus.div_req_valid = 1'b1;
        bus.div_cancel    = 1'b1;
        #1;
        checks++;
        if (bus.div_req_ready !== 1'b0) begin
            $display("FAIL cancel_idle_ready: req_ready=%0b required=0", bus.div_req_ready);
            failures++;
        end
        tick();
        bus.div_req_valid = 1'b0;
        bus.div_cancel    = 1'b0;
        #1;
        checks++;
        if (bus.div_busy !== 1'b0) begin
            $display("FAIL cancel_idle_accept: busy=%0b required=0", bus.div_busy);
            failures++;
        end
        // Cancel coinciding with res_ready in DONE.
        bus.div_res_ready = 1'b0;
        issue(1'b1, 32'hFFFF_FFCE, 32'd7);
        wait_valid(n);
        checks++;
        if (n !== DW + 1) begin
            $display("FAIL cancel_done_latency: got=%0d required=%0d", n, DW + 1);
            failures++;
        end
        bus.div_cancel    = 1'b1;
        bus.div_res_ready = 1'b1;
        tick();
        bus.div_cancel = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.div_res_valid || bus.div_busy) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL cancel_done: result_or_busy_seen=%0b required=0", seen);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        bus.div_res_ready = 1'b1;
        issue(1'b0, 32'd12345, 32'd67);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.div_res_valid !== 1'b0 || bus.div_busy !== 1'b0 || bus.div_quot !== '0 ||
            bus.div_rem !== '0 || bus.div_req_ready !== 1'b1) begin
            $display("FAIL reset_mid: valid=%0b busy=%0b quot=%h rem=%h ready=%0b required 0/0/0/0/1",
                     bus.div_res_valid, bus.div_busy, bus.div_quot, bus.div_rem, bus.div_req_ready);
            failures++;
        end
        run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "divu_9_3_after_reset");
    endtask

    task automatic test_random();
        int n;
        int hold;
        logic          sgn;
        logic [DW-1:0] a, b, q, r, eq, er;
        for (int k = 0; k < 40; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = pick_operand();
            b   = pick_operand();
            ref_div(sgn, a, b, q, r);
            exp_q.push_back(q);
            exp_r.push_back(r);
            hold = $urandom_range(0, 3);
            bus.div_res_ready = (hold == 0);
            issue(sgn, a, b);
            wait_valid(n);
            checks++;
            if (n !== DW + 1) begin
                $display("FAIL rand_latency: op=%0d got=%0d required=%0d", k, n, DW + 1);
                failures++;
            end
            for (int i = 0; i < hold; i++) tick();
            eq = exp_q.pop_front();
            er = exp_r.pop_front();
            checks++;
            if (bus.div_res_valid !== 1'b1 || bus.div_quot !== eq || bus.div_rem !== er) begin
                $display("FAIL rand_result: op=%0d s=%0b a=%h b=%h valid=%0b quot=%h rem=%h required quot=%h rem=%h",
                         k, sgn, a, b, bus.div_res_valid, bus.div_quot, bus.div_rem, eq, er);
                failures++;
            end
            bus.div_res_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
